// File: rtl/sudoku_sweep_ctrl.sv
// Sweep sequencer for an 81-cell sudoku grid: one shared full-house filler is
// time-multiplexed over the 9 rows, 9 columns and 9 boxes, pass after pass.
module sudoku_sweep_ctrl #(
    parameter int MAX_PASSES = 16,
    parameter int PCW        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [323:0]     grid_in,
    output logic [35:0]      fill_req,
    input  logic [35:0]      fill_rsp,
    output logic [323:0]     grid_out,
    output logic             busy,
    output logic             done,
    output logic             solved,
    output logic             stalled,
    output logic [PCW-1:0]   pass_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       g_q, g_d;
    logic [323:0]     grid_q, grid_d;
    logic             progress_q, progress_d;
    logic             solved_q, solved_d;
    logic             stalled_q, stalled_d;
    logic [PCW-1:0]   pass_q, pass_d;
    logic             has_blank;

    // Linear cell index (9*r+c) of slot k within group g: rows, then columns, then boxes.
    function automatic logic [6:0] cell_idx(input logic [4:0] g, input logic [3:0] k);
        int gi;
        int ki;
        int r;
        int c;
        gi = int'(g);
        ki = int'(k);
        if (gi < 9) begin
            r = gi;
            c = ki;
        end else if (gi < 18) begin
            r = ki;
            c = gi - 9;
        end else if (gi < 27) begin
            r = 3 * ((gi - 18) / 3) + ki / 3;
            c = 3 * ((gi - 18) % 3) + ki % 3;
        end else begin
            r = 0;
            c = 0;
        end
        return 7'(9 * r + c);
    endfunction

    always_comb begin
        fill_req = '0;
        if (state_q == S_SWEEP) begin
            for (int k = 0; k < 9; k++) begin
                fill_req[4*k +: 4] = grid_q[{cell_idx(g_q, 4'(k)), 2'b00} +: 4];
            end
        end
    end

    always_comb begin
        has_blank = 1'b0;
        for (int i = 0; i < 81; i++) begin
            if (grid_q[4*i +: 4] == 4'd0) begin
                has_blank = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        grid_d     = grid_q;
        progress_d = progress_q;
        solved_d   = solved_q;
        stalled_d  = stalled_q;
        pass_d     = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    grid_d     = grid_in;
                    solved_d   = 1'b0;
                    stalled_d  = 1'b0;
                    pass_d     = '0;
                    g_d        = 5'd0;
                    progress_d = 1'b0;
                    state_d    = S_SWEEP;
                end
            end
            S_SWEEP: begin
                // Only blanks accept a digit, and only a legal 1..9 one.
                for (int k = 0; k < 9; k++) begin
                    if (fill_req[4*k +: 4] == 4'd0 &&
                        fill_rsp[4*k +: 4] != 4'd0 &&
                        fill_rsp[4*k +: 4] <= 4'd9) begin
                        grid_d[{cell_idx(g_q, 4'(k)), 2'b00} +: 4] = fill_rsp[4*k +: 4];
                        progress_d = 1'b1;
                    end
                end
                if (g_q == 5'd26) begin
                    pass_d  = pass_q + PCW'(1);
                    state_d = S_CHECK;
                end else begin
                    g_d = g_q + 5'd1;
                end
            end
            S_CHECK: begin
                if (!has_blank) begin
                    solved_d = 1'b1;
                    state_d  = S_DONE;
                end else if (!progress_q || pass_q == PCW'(MAX_PASSES)) begin
                    stalled_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    g_d        = 5'd0;
                    progress_d = 1'b0;
                    state_d    = S_SWEEP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            g_q        <= 5'd0;
            grid_q     <= '0;
            progress_q <= 1'b0;
            solved_q   <= 1'b0;
            stalled_q  <= 1'b0;
            pass_q     <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            grid_q     <= grid_d;
            progress_q <= progress_d;
            solved_q   <= solved_d;
            stalled_q  <= stalled_d;
            pass_q     <= pass_d;
        end
    end

    assign grid_out   = grid_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign solved     = solved_q;
    assign stalled    = stalled_q;
    assign pass_count = pass_q;

endmodule

// File: tb/tb_sudoku_sweep_ctrl.sv
// Self-checking bench for sudoku_sweep_ctrl: a sweep-level grid model predicts every
// cycle of each run; two instances cover MAX_PASSES=16 and MAX_PASSES=1.
module tb_sudoku_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_a, start_b;
    logic [323:0] grid_in;
    logic [35:0]  req_a, rsp_a, req_b, rsp_b;
    logic [323:0] gout_a, gout_b;
    logic         busy_a, busy_b, done_a, done_b;
    logic         solved_a, solved_b, stalled_a, stalled_b;
    logic [7:0]   pc_a, pc_b;
    int           mode_a, mode_b;
    logic [35:0]  noise_a, noise_b;

    int total = 0;
    int bad   = 0;
    int perm[9];

    typedef struct {
        logic [323:0] grid;
        logic [35:0]  req;
        logic         busy;
        logic         done;
        logic         solved;
        logic         stalled;
        int           pass;
    } snap_t;

    snap_t expa[$];
    snap_t expb[$];

    sudoku_sweep_ctrl #(.MAX_PASSES(16), .PCW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .grid_in(grid_in),
        .fill_req(req_a), .fill_rsp(rsp_a), .grid_out(gout_a),
        .busy(busy_a), .done(done_a), .solved(solved_a), .stalled(stalled_a),
        .pass_count(pc_a)
    );

    sudoku_sweep_ctrl #(.MAX_PASSES(1), .PCW(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .grid_in(grid_in),
        .fill_req(req_b), .fill_rsp(rsp_b), .grid_out(gout_b),
        .busy(busy_b), .done(done_b), .solved(solved_b), .stalled(stalled_b),
        .pass_count(pc_b)
    );

    // Full-house filler: a lone blank gets the missing digit; every other slot gets
    // junk that must be ignored. Mode 1 answers 4'hF everywhere.
    function automatic logic [35:0] filler(input logic [35:0] req, input int mode,
                                           input logic [35:0] noise);
        logic [35:0] rsp;
        logic [9:0]  seen;
        logic [3:0]  n;
        logic [3:0]  miss;
        int          blanks;
        rsp    = '0;
        seen   = '0;
        blanks = 0;
        miss   = 4'd0;
        if (mode == 1) return {9{4'hF}};
        for (int k = 0; k < 9; k++) begin
            n = req[4*k +: 4];
            if (n == 4'd0) blanks++;
            else if (n <= 4'd9) seen[n] = 1'b1;
        end
        for (int d = 9; d >= 1; d--) if (!seen[d]) miss = 4'(d);
        for (int k = 0; k < 9; k++) begin
            n = req[4*k +: 4];
            if (n != 4'd0)       rsp[4*k +: 4] = noise[4*k +: 4];
            else if (blanks == 1) rsp[4*k +: 4] = miss;
            else                 rsp[4*k +: 4] = noise[4*k] ? 4'h0 : 4'hC;
        end
        return rsp;
    endfunction

    always_comb rsp_a = filler(req_a, mode_a, noise_a);
    always_comb rsp_b = filler(req_b, mode_b, noise_b);

    always @(negedge clk) begin
        noise_a = {4'($urandom), $urandom};
        noise_b = {4'($urandom), $urandom};
    end

    function automatic bit in_group(input int g, input int r, input int c);
        if (g < 9)  return r == g;
        if (g < 18) return c == g - 9;
        return (r / 3) * 3 + c / 3 == g - 18;
    endfunction

    function automatic logic [323:0] make_sol();
        logic [323:0] s;
        s = '0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                s[4*(9*r+c) +: 4] = 4'(perm[(r*3 + r/3 + c) % 9]);
        return s;
    endfunction

    function automatic logic [323:0] blank(input logic [323:0] g, input int r, input int c);
        g[4*(9*r+c) +: 4] = 4'd0;
        return g;
    endfunction

    task automatic cmp(input string name, input logic [323:0] act, input logic [323:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Walks the sweeps at grid level and queues the expected outputs for every cycle.
    task automatic build_expect(input int dut, input logic [323:0] gin, input int maxp,
                                input int mode, output logic [323:0] fgrid, output int fpass,
                                output logic fsolved, output logic fstalled, output int done_at);
        logic [3:0]   cells[81];
        int           members[9];
        logic [35:0]  req;
        logic [35:0]  rsp;
        logic [323:0] packed_grid;
        snap_t        s;
        int           n, pass, cyc, blanks;
        bit           progress, finished;
        for (int i = 0; i < 81; i++) cells[i] = gin[4*i +: 4];
        pass = 0; cyc = 0; finished = 0; fsolved = 0; fstalled = 0;
        while (!finished) begin
            progress = 0;
            for (int g = 0; g < 27; g++) begin
                n = 0;
                for (int r = 0; r < 9; r++)
                    for (int c = 0; c < 9; c++)
                        if (in_group(g, r, c)) begin members[n] = 9*r + c; n++; end
                for (int k = 0; k < 9; k++) req[4*k +: 4] = cells[members[k]];
                for (int i = 0; i < 81; i++) packed_grid[4*i +: 4] = cells[i];
                s = '{grid: packed_grid, req: req, busy: 1, done: 0, solved: 0, stalled: 0, pass: pass};
                if (dut == 0) expa.push_back(s); else expb.push_back(s);
                cyc++;
                rsp = filler(req, mode, '0);
                for (int k = 0; k < 9; k++)
                    if (req[4*k +: 4] == 0 && rsp[4*k +: 4] >= 1 && rsp[4*k +: 4] <= 9) begin
                        cells[members[k]] = rsp[4*k +: 4];
                        progress = 1;
                    end
            end
            pass++;
            for (int i = 0; i < 81; i++) packed_grid[4*i +: 4] = cells[i];
            s = '{grid: packed_grid, req: '0, busy: 1, done: 0, solved: 0, stalled: 0, pass: pass};
            if (dut == 0) expa.push_back(s); else expb.push_back(s);
            cyc++;
            blanks = 0;
            for (int i = 0; i < 81; i++) if (cells[i] == 0) blanks++;
            if (blanks == 0) begin fsolved = 1; finished = 1; end
            else if (!progress || pass >= maxp) begin fstalled = 1; finished = 1; end
        end
        s = '{grid: packed_grid, req: '0, busy: 1, done: 1, solved: fsolved, stalled: fstalled, pass: pass};
        if (dut == 0) expa.push_back(s); else expb.push_back(s);
        cyc++;
        done_at = cyc;
        s.busy = 0;
        s.done = 0;
        for (int i = 0; i < 2; i++) if (dut == 0) expa.push_back(s); else expb.push_back(s);
        fgrid = packed_grid;
        fpass = pass;
    endtask

    task automatic checkOutput(input int dut, input snap_t s);
        string t;
        t = (dut == 0) ? "A" : "B";
        if (dut == 0) begin
            cmp({t, ".grid"}, gout_a, s.grid);
            cmp({t, ".fill_req"}, 324'(req_a), 324'(s.req));
            cmp({t, ".busy"}, 324'(busy_a), 324'(s.busy));
            cmp({t, ".done"}, 324'(done_a), 324'(s.done));
            cmp({t, ".solved"}, 324'(solved_a), 324'(s.solved));
            cmp({t, ".stalled"}, 324'(stalled_a), 324'(s.stalled));
            cmp({t, ".pass_count"}, 324'(pc_a), 324'(s.pass));
        end else begin
            cmp({t, ".grid"}, gout_b, s.grid);
            cmp({t, ".fill_req"}, 324'(req_b), 324'(s.req));
            cmp({t, ".busy"}, 324'(busy_b), 324'(s.busy));
            cmp({t, ".done"}, 324'(done_b), 324'(s.done));
            cmp({t, ".solved"}, 324'(solved_b), 324'(s.solved));
            cmp({t, ".stalled"}, 324'(stalled_b), 324'(s.stalled));
            cmp({t, ".pass_count"}, 324'(pc_b), 324'(s.pass));
        end
    endtask

    always @(negedge clk) begin
        snap_t sa;
        snap_t sb;
        if (expa.size() > 0) begin sa = expa.pop_front(); checkOutput(0, sa); end
        if (expb.size() > 0) begin sb = expb.pop_front(); checkOutput(1, sb); end
    end

    task automatic applyStimulus(input int dut, input logic [323:0] gin, input int mode,
                                 output logic [323:0] fgrid, output int fpass,
                                 output logic fsol, output logic fstall, output int done_at);
        @(posedge clk);
        #1;
        grid_in = gin;
        if (dut == 0) begin mode_a = mode; start_a = 1'b1; end
        else          begin mode_b = mode; start_b = 1'b1; end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        build_expect(dut, gin, (dut == 0) ? 16 : 1, mode, fgrid, fpass, fsol, fstall, done_at);
    endtask

    task automatic wait_drain(input int dut);
        int left;
        left = 1;
        for (int i = 0; i < 2000 && left > 0; i++) begin
            @(negedge clk);
            left = (dut == 0) ? expa.size() : expb.size();
        end
        @(posedge clk);
        left = (dut == 0) ? expa.size() : expb.size();
        total++;
        if (left != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", left);
            expa.delete();
            expb.delete();
        end
    endtask

    task automatic check_final(input int dut, input string name, input logic [323:0] g,
                               input int p, input logic sv, input logic st);
        if (dut == 0) begin
            cmp({name, ".grid"}, gout_a, g);
            cmp({name, ".pass"}, 324'(pc_a), 324'(p));
            cmp({name, ".solved"}, 324'(solved_a), 324'(sv));
            cmp({name, ".stalled"}, 324'(stalled_a), 324'(st));
        end else begin
            cmp({name, ".grid"}, gout_b, g);
            cmp({name, ".pass"}, 324'(pc_b), 324'(p));
            cmp({name, ".solved"}, 324'(solved_b), 324'(sv));
            cmp({name, ".stalled"}, 324'(stalled_b), 324'(st));
        end
    endtask

    task automatic check_reset_state(input string name);
        cmp({name, ".busy"}, 324'({busy_a, busy_b}), 324'(0));
        cmp({name, ".done"}, 324'({done_a, done_b}), 324'(0));
        cmp({name, ".flags"}, 324'({solved_a, stalled_a, solved_b, stalled_b}), 324'(0));
        cmp({name, ".pass"}, 324'({pc_a, pc_b}), 324'(0));
        cmp({name, ".grid_a"}, gout_a, '0);
        cmp({name, ".grid_b"}, gout_b, '0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [323:0] sol, p1, p3, fg;
        int           fp, da, nb, tmp, j, mode;
        logic         fs, ft;

        for (int i = 0; i < 9; i++) perm[i] = i + 1;
        sol = make_sol();
        p1  = blank(blank(sol, 0, 0), 8, 8);
        p3  = blank(blank(blank(blank(blank(sol, 0, 0), 0, 1), 1, 1), 1, 2), 2, 2);

        rst = 1'b1; start_a = 1'b1; start_b = 1'b1; grid_in = sol;
        mode_a = 0; mode_b = 0; noise_a = '0; noise_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        $display("[TB] two blanks, one pass");
        applyStimulus(0, p1, 0, fg, fp, fs, ft, da);
        wait_drain(0);
        cmp("p1.done_at", 324'(da), 324'(29));
        check_final(0, "p1", sol, 1, 1'b1, 1'b0);

        $display("[TB] all-zero grid");
        applyStimulus(0, '0, 0, fg, fp, fs, ft, da);
        wait_drain(0);
        cmp("zero.done_at", 324'(da), 324'(29));
        check_final(0, "zero", '0, 1, 1'b0, 1'b1);

        $display("[TB] row/column dependency");
        applyStimulus(0, p3, 0, fg, fp, fs, ft, da);
        wait_drain(0);
        cmp("dep.done_at", 324'(da), 324'(57));
        check_final(0, "dep", sol, 2, 1'b1, 1'b0);

        $display("[TB] filler returns 4'hF");
        applyStimulus(0, blank(sol, 4, 4), 1, fg, fp, fs, ft, da);
        wait_drain(0);
        check_final(0, "badfill", blank(sol, 4, 4), 1, 1'b0, 1'b1);

        $display("[TB] pass limit of one");
        applyStimulus(1, p3, 0, fg, fp, fs, ft, da);
        wait_drain(1);
        check_final(1, "limit", fg, 1, 1'b0, 1'b1);
        cmp("limit.cell00", 324'(gout_b[3:0]), 324'(sol[3:0]));
        cmp("limit.cell01", 324'(gout_b[7:4]), 324'(0));

        $display("[TB] start pulse while busy");
        applyStimulus(0, p1, 0, fg, fp, fs, ft, da);
        repeat (4) @(posedge clk);
        #1;
        start_a = 1'b1; grid_in = '0;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        wait_drain(0);
        check_final(0, "pulse", sol, 1, 1'b1, 1'b0);

        $display("[TB] reset mid-sweep");
        applyStimulus(0, p3, 0, fg, fp, fs, ft, da);
        repeat (9) @(posedge clk);
        #1;
        expa.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        applyStimulus(0, p1, 0, fg, fp, fs, ft, da);
        wait_drain(0);
        check_final(0, "after_rst", sol, 1, 1'b1, 1'b0);

        $display("[TB] random puzzles");
        for (int t = 0; t < 8; t++) begin
            for (int i = 8; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            p1 = make_sol();
            nb = $urandom_range(1, 50);
            for (int i = 0; i < nb; i++) p1 = blank(p1, $urandom_range(0, 8), $urandom_range(0, 8));
            mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
            applyStimulus(t % 2, p1, mode, fg, fp, fs, ft, da);
            wait_drain(t % 2);
            check_final(t % 2, "rand", fg, fp, fs, ft);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
